// File: rtl/cp0_exc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_unit_pkg
// Description : Shared CP0 defines: register numbers, exception type codes,
//               ExcCode values, Status/Cause field positions, flag positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_exc_unit_pkg;

  localparam int EXC_TYPE_BUS = 4;

  // CP0 register numbers
  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;

  // Exception types handed to the pipeline controller, in priority order
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_NULL    = 4'd0;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_INT     = 4'd1;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ADEL_IF = 4'd2;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_RI      = 4'd3;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_OV      = 4'd4;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_SYS     = 4'd5;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_BP      = 4'd6;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ADEL_D  = 4'd7;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ADES    = 4'd8;
  localparam logic [EXC_TYPE_BUS-1:0] EXC_TYPE_ERET    = 4'd9;

  // Cause.ExcCode values
  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  // Status / Cause field positions and software-writable masks
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;
  localparam logic [31:0] STATUS_WR_MASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WR_MASK  = 32'h0000_0300;

  // Bit positions inside mem_exc_flags
  localparam int FLAG_ADES_D  = 0;
  localparam int FLAG_ADEL_D  = 1;
  localparam int FLAG_BP      = 2;
  localparam int FLAG_SYS     = 3;
  localparam int FLAG_OV      = 4;
  localparam int FLAG_RI      = 5;
  localparam int FLAG_ADEL_IF = 6;
  localparam int FLAG_ERET    = 7;

  // ExcCode recorded in Cause for a committed exception type
  function automatic logic [4:0] exc_code(input logic [EXC_TYPE_BUS-1:0] t);
    case (t)
      EXC_TYPE_ADEL_IF, EXC_TYPE_ADEL_D: exc_code = EXCCODE_ADEL;
      EXC_TYPE_ADES:                     exc_code = EXCCODE_ADES;
      EXC_TYPE_RI:                       exc_code = EXCCODE_RI;
      EXC_TYPE_OV:                       exc_code = EXCCODE_OV;
      EXC_TYPE_SYS:                      exc_code = EXCCODE_SYS;
      EXC_TYPE_BP:                       exc_code = EXCCODE_BP;
      default:                           exc_code = EXCCODE_INT;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : CP0 Count/Compare timer. Count advances on each tick (every
//               second cycle when COUNT_HALF != 0), TI latches on
//               Count==Compare and is cleared by a Compare write.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer #(
  parameter int COUNT_HALF = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_inc;

  assign w_inc   = (COUNT_HALF != 0) ? r_tick : 1'b1;
  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

  // Tick divider, Count/Compare registers and the sticky timer interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick    <= 1'b0;
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (wr_count)   r_count <= wr_data;
      else if (w_inc) r_count <= r_count + 32'd1;
      if (wr_compare) r_compare <= wr_data;
      // A Compare write acknowledges the interrupt and wins over a match
      if (wr_compare)                  r_ti <= 1'b0;
      else if (r_count == r_compare)   r_ti <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_unit
// Description : CP0 register file and commit-point exception arbiter. Picks
//               the highest-priority exception of the MEM instruction, and
//               commits EPC/Cause/Status/BadVAddr only on unstalled cycles.
//               Define CP0_TIMER_INT_EN to build the Count/Compare timer.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          COUNT_HALF = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_valid,
  input  logic [31:0]             mem_pc,
  input  logic                    mem_in_ds,
  input  logic [7:0]              mem_exc_flags,
  input  logic [31:0]             mem_badaddr,
  input  logic                    mem_stall,
  input  logic [5:0]              hw_int,
  input  logic                    wr_en,
  input  logic [4:0]              wr_addr,
  input  logic [31:0]             wr_data,
  input  logic [4:0]              rd_addr,
  output logic [31:0]             rd_data,
  output logic [EXC_TYPE_BUS-1:0] exception_type,
  output logic [31:0]             cp0_epc,
  output logic [31:0]             status_o,
  output logic [31:0]             cause_o,
  output logic                    timer_int
);

  logic [31:0] r_status, r_cause, r_epc, r_badvaddr;
  logic [31:0] w_status_fwd, w_cause_st_fwd, w_cause_live, w_cause_fwd, w_epc_fwd;
  logic [31:0] w_status_nxt, w_cause_nxt, w_epc_nxt, w_badv_nxt;
  logic [31:0] w_count_rd, w_compare_rd;
  logic        w_ti, w_int_pend, w_commit;
  logic [EXC_TYPE_BUS-1:0] w_exc_type;

`ifdef CP0_TIMER_INT_EN
  logic        w_wr_count, w_wr_compare;
  logic [31:0] w_count, w_compare;

  assign w_wr_count   = wr_en && (wr_addr == CP0_REG_COUNT);
  assign w_wr_compare = wr_en && (wr_addr == CP0_REG_COMPARE);

  cp0_timer #(.COUNT_HALF(COUNT_HALF)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .wr_count   (w_wr_count),
    .wr_compare (w_wr_compare),
    .wr_data    (wr_data),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );

  assign w_count_rd   = w_wr_count   ? wr_data : w_count;
  assign w_compare_rd = w_wr_compare ? wr_data : w_compare;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (COUNT_HALF != 0);
  assign w_count_rd   = 32'd0;
  assign w_compare_rd = 32'd0;
  assign w_ti         = 1'b0;
`endif

  // Same-cycle MTC0 is merged in so the arbiter and readers see it at once
  assign w_status_fwd   = (wr_en && (wr_addr == CP0_REG_STATUS)) ?
                          ((r_status & ~STATUS_WR_MASK) | (wr_data & STATUS_WR_MASK)) : r_status;
  assign w_cause_st_fwd = (wr_en && (wr_addr == CP0_REG_CAUSE)) ?
                          ((r_cause & ~CAUSE_WR_MASK) | (wr_data & CAUSE_WR_MASK)) : r_cause;
  assign w_epc_fwd      = (wr_en && (wr_addr == CP0_REG_EPC)) ? wr_data : r_epc;
  assign w_cause_fwd    = w_cause_st_fwd | w_cause_live;

  // Hardware pending bits and TI track their sources live, never stored
  always_comb begin
    w_cause_live                      = 32'd0;
    w_cause_live[CAUSE_TI]            = w_ti;
    w_cause_live[CAUSE_IP_LO + 7]     = hw_int[5] | w_ti;
    w_cause_live[CAUSE_IP_LO + 2 +: 5] = hw_int[4:0];
  end

  assign w_int_pend = mem_valid && w_status_fwd[STATUS_IE] && !w_status_fwd[STATUS_EXL] &&
                      (|(w_cause_fwd[CAUSE_IP_LO +: 8] & w_status_fwd[STATUS_IM_LO +: 8]));

  // Fixed-priority exception pick for the MEM instruction
  always_comb begin
    w_exc_type = EXC_TYPE_NULL;
    if (mem_valid) begin
      if (w_int_pend)                         w_exc_type = EXC_TYPE_INT;
      else if (mem_exc_flags[FLAG_ADEL_IF])   w_exc_type = EXC_TYPE_ADEL_IF;
      else if (mem_exc_flags[FLAG_RI])        w_exc_type = EXC_TYPE_RI;
      else if (mem_exc_flags[FLAG_OV])        w_exc_type = EXC_TYPE_OV;
      else if (mem_exc_flags[FLAG_SYS])       w_exc_type = EXC_TYPE_SYS;
      else if (mem_exc_flags[FLAG_BP])        w_exc_type = EXC_TYPE_BP;
      else if (mem_exc_flags[FLAG_ADEL_D])    w_exc_type = EXC_TYPE_ADEL_D;
      else if (mem_exc_flags[FLAG_ADES_D])    w_exc_type = EXC_TYPE_ADES;
      else if (mem_exc_flags[FLAG_ERET])      w_exc_type = EXC_TYPE_ERET;
    end
  end

  assign w_commit = (w_exc_type != EXC_TYPE_NULL) && !mem_stall;

  // Next CP0 state: MTC0 result first, commit fields layered on top
  always_comb begin
    w_status_nxt = w_status_fwd;
    w_cause_nxt  = w_cause_st_fwd;
    w_epc_nxt    = w_epc_fwd;
    w_badv_nxt   = r_badvaddr;
    if (w_commit) begin
      if (w_exc_type == EXC_TYPE_ERET) begin
        w_status_nxt[STATUS_EXL] = 1'b0;
      end else begin
        // A nested exception keeps the original return address
        if (!w_status_fwd[STATUS_EXL]) begin
          w_epc_nxt             = mem_in_ds ? (mem_pc - 32'd4) : mem_pc;
          w_cause_nxt[CAUSE_BD] = mem_in_ds;
        end
        w_status_nxt[STATUS_EXL]        = 1'b1;
        w_cause_nxt[CAUSE_EXC_LO +: 5]  = exc_code(w_exc_type);
        if (w_exc_type == EXC_TYPE_ADEL_IF)
          w_badv_nxt = mem_pc;
        else if ((w_exc_type == EXC_TYPE_ADEL_D) || (w_exc_type == EXC_TYPE_ADES))
          w_badv_nxt = mem_badaddr;
      end
    end
  end

  // CP0 state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_status   <= STATUS_RST;
      r_cause    <= 32'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else begin
      r_status   <= w_status_nxt;
      r_cause    <= w_cause_nxt;
      r_epc      <= w_epc_nxt;
      r_badvaddr <= w_badv_nxt;
    end
  end

  // MFC0 read port; unimplemented registers read zero
  always_comb begin
    rd_data = 32'd0;
    case (rd_addr)
      CP0_REG_BADVADDR: rd_data = r_badvaddr;
      CP0_REG_COUNT:    rd_data = w_count_rd;
      CP0_REG_COMPARE:  rd_data = w_compare_rd;
      CP0_REG_STATUS:   rd_data = w_status_fwd;
      CP0_REG_CAUSE:    rd_data = w_cause_fwd;
      CP0_REG_EPC:      rd_data = w_epc_fwd;
      default:          rd_data = 32'd0;
    endcase
  end

  assign exception_type = w_exc_type;
  assign cp0_epc        = w_epc_fwd;
  assign status_o       = w_status_fwd;
  assign cause_o        = w_cause_fwd;
  assign timer_int      = w_ti;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_exc_unit
// Description : Self-checking bench for cp0_exc_unit: directed scenarios plus
//               randomized traffic against a behavioural CP0 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_unit;

`ifdef CP0_TIMER_INT_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, mem_valid, mem_in_ds, mem_stall, wr_en;
  logic [31:0] mem_pc, mem_badaddr, wr_data;
  logic [7:0]  mem_exc_flags;
  logic [5:0]  hw_int;
  logic [4:0]  wr_addr, rd_addr;
  logic [31:0] rd_data, cp0_epc, status_o, cause_o;
  logic [3:0]  exception_type;
  logic        timer_int;

  int total = 0;
  int bad   = 0;

  // Model state
  bit [31:0] m_status, m_epc, m_badv, m_count, m_compare;
  bit        m_bd, m_ti;
  bit [1:0]  m_ipsw;
  bit [4:0]  m_exc;
  int        m_cycles;
  // Model expectations for the current cycle
  int        e_type;
  bit [31:0] e_status, e_cause, e_epc, e_rd;
  bit        e_ti;

  cp0_exc_unit dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_in_ds(mem_in_ds), .mem_exc_flags(mem_exc_flags), .mem_badaddr(mem_badaddr),
    .mem_stall(mem_stall), .hw_int(hw_int), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .exception_type(exception_type), .cp0_epc(cp0_epc), .status_o(status_o),
    .cause_o(cause_o), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [4:0] code_of(input int t);
    case (t)
      1:       return 5'd0;
      2, 7:    return 5'd4;
      3:       return 5'd10;
      4:       return 5'd12;
      5:       return 5'd8;
      6:       return 5'd9;
      8:       return 5'd5;
      default: return 5'd0;
    endcase
  endfunction

  // Expected combinational view from model state and current inputs
  task automatic model_eval();
    bit [31:0] sm;
    bit        ti, int_p;
    bit [1:0]  ipsw;
    bit [8:0]  cand;
    sm = 32'h0000_FF03;
    ti = TIMER ? m_ti : 1'b0;
    e_status = (wr_en && wr_addr == 5'd12) ? ((m_status & ~sm) | (wr_data & sm)) : m_status;
    ipsw     = (wr_en && wr_addr == 5'd13) ? wr_data[9:8] : m_ipsw;
    e_cause  = {m_bd, ti, 14'd0, hw_int[5] | ti, hw_int[4:0], ipsw, 1'b0, m_exc, 2'b00};
    e_epc    = (wr_en && wr_addr == 5'd14) ? wr_data : m_epc;
    e_ti     = ti;
    int_p    = mem_valid && e_status[0] && !e_status[1] && ((e_cause[15:8] & e_status[15:8]) != 8'd0);
    cand     = {mem_exc_flags[7], mem_exc_flags[0], mem_exc_flags[1], mem_exc_flags[2],
                mem_exc_flags[3], mem_exc_flags[4], mem_exc_flags[5], mem_exc_flags[6], int_p};
    e_type = 0;
    if (mem_valid) begin
      for (int k = 0; k < 9; k++) begin
        if (cand[k]) begin
          e_type = k + 1;
          break;
        end
      end
    end
    case (rd_addr)
      5'd8:    e_rd = m_badv;
      5'd9:    e_rd = !TIMER ? 32'd0 : ((wr_en && wr_addr == 5'd9) ? wr_data : m_count);
      5'd11:   e_rd = !TIMER ? 32'd0 : ((wr_en && wr_addr == 5'd11) ? wr_data : m_compare);
      5'd12:   e_rd = e_status;
      5'd13:   e_rd = e_cause;
      5'd14:   e_rd = e_epc;
      default: e_rd = 32'd0;
    endcase
  endtask

  // Advance the model across one clock edge
  task automatic model_edge();
    bit [31:0] old_count, old_cmp;
    if (reset) begin
      m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
      m_bd = 0; m_ti = 0; m_ipsw = 0; m_exc = 0; m_cycles = 0;
    end else begin
      old_count = m_count;
      old_cmp   = m_compare;
      m_status  = e_status;
      m_ipsw    = e_cause[9:8];
      m_epc     = e_epc;
      if (e_type != 0 && !mem_stall) begin
        if (e_type == 9) begin
          m_status[1] = 1'b0;
        end else begin
          if (!e_status[1]) begin
            m_epc = mem_in_ds ? mem_pc - 32'd4 : mem_pc;
            m_bd  = mem_in_ds;
          end
          m_status[1] = 1'b1;
          m_exc = code_of(e_type);
          if (e_type == 2) m_badv = mem_pc;
          else if (e_type == 7 || e_type == 8) m_badv = mem_badaddr;
        end
      end
      if (TIMER) begin
        if (wr_en && wr_addr == 5'd11) begin
          m_compare = wr_data;
          m_ti = 1'b0;
        end else if (old_count == old_cmp) begin
          m_ti = 1'b1;
        end
        if (wr_en && wr_addr == 5'd9) m_count = wr_data;
        else if ((m_cycles % 2) == 1) m_count = old_count + 32'd1;
      end
      m_cycles++;
    end
  endtask

  // Inputs are already set at a negedge: check, take the edge, return at next negedge
  task automatic run_cycle();
    #1;
    model_eval();
    chk("exc_type", {28'd0, exception_type}, e_type);
    chk("cp0_epc", cp0_epc, e_epc);
    chk("status", status_o, e_status);
    chk("cause", cause_o, e_cause);
    chk("timer_int", {31'd0, timer_int}, {31'd0, e_ti});
    chk("rd_data", rd_data, e_rd);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; mem_valid = 0; mem_in_ds = 0; mem_stall = 0; wr_en = 0;
    mem_pc = 0; mem_badaddr = 0; wr_data = 0; mem_exc_flags = 0; hw_int = 0;
    wr_addr = 0; rd_addr = 5'd12;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic randomize_inputs();
    int sel;
    bit [4:0] addrs [8];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
    reset     = ($urandom_range(99) == 0);
    mem_valid = ($urandom_range(3) != 0);
    mem_pc    = {$urandom, 2'b00} >> 0;
    mem_pc    = $urandom & 32'hFFFF_FFFC;
    mem_in_ds = $urandom_range(1);
    sel = $urandom_range(3);
    mem_exc_flags = (sel == 0) ? 8'($urandom) : (sel == 1) ? (8'd1 << $urandom_range(7)) : 8'd0;
    mem_badaddr = $urandom;
    mem_stall   = ($urandom_range(3) == 0);
    hw_int      = ($urandom_range(4) == 0) ? 6'($urandom) : 6'd0;
    wr_en       = ($urandom_range(4) == 0);
    wr_addr     = addrs[$urandom_range(7)];
    wr_data     = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(40));
    rd_addr     = addrs[$urandom_range(7)];
  endtask

  initial begin
    bit seen;
    idle();
    reset = 1;
    @(negedge clk);
    do_reset();

    // Reset values
    #1;
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_epc", cp0_epc, 32'd0);
    chk("rst_cause", cause_o, 32'd0);
    chk("rst_type", {28'd0, exception_type}, 32'd0);

    // Interrupt enabled by a same-cycle MTC0 Status write
    wr_en = 1; wr_addr = 5'd12; wr_data = 32'h0000_0401; hw_int = 6'd1;
    mem_valid = 1; mem_pc = 32'h8000_0200;
    #1 chk("int_type", {28'd0, exception_type}, 32'd1);
    run_cycle();
    idle(); #1;
    chk("int_epc", cp0_epc, 32'h8000_0200);
    chk("int_exl", {31'd0, status_o[1]}, 32'd1);
    chk("int_code", {27'd0, cause_o[6:2]}, 32'd0);

    // OV beats SYS; delay-slot EPC and BD
    do_reset();
    mem_valid = 1; mem_exc_flags = 8'h18; mem_in_ds = 1; mem_pc = 32'hBFC0_0104;
    #1 chk("ov_type", {28'd0, exception_type}, 32'd4);
    run_cycle();
    idle(); #1;
    chk("ov_epc", cp0_epc, 32'hBFC0_0100);
    chk("ov_bd", {31'd0, cause_o[31]}, 32'd1);
    chk("ov_code", {27'd0, cause_o[6:2]}, 32'd12);

    // ADES held by a 3-cycle stall, committed on release
    do_reset();
    mem_valid = 1; mem_exc_flags = 8'h01; mem_badaddr = 32'h8000_0003;
    mem_pc = 32'h8000_0100; mem_stall = 1; rd_addr = 5'd8;
    repeat (3) begin
      #1 chk("stall_type", {28'd0, exception_type}, 32'd8);
      run_cycle();
      chk("stall_status", status_o, 32'h0040_0000);
      chk("stall_badv", rd_data, 32'd0);
    end
    mem_stall = 0;
    run_cycle();
    idle(); rd_addr = 5'd8; #1;
    chk("ades_badv", rd_data, 32'h8000_0003);
    chk("ades_code", {27'd0, cause_o[6:2]}, 32'd5);

    // Nested RI with EXL=1 keeps EPC/BD, then ERET clears EXL
    mem_valid = 1; mem_exc_flags = 8'h20; mem_pc = 32'h8000_0300; mem_in_ds = 1;
    run_cycle();
    idle(); #1;
    chk("ri_code", {27'd0, cause_o[6:2]}, 32'd10);
    chk("ri_epc", cp0_epc, 32'h8000_0100);
    chk("ri_bd", {31'd0, cause_o[31]}, 32'd0);
    mem_valid = 1; mem_exc_flags = 8'h80; mem_pc = 32'h8000_0400;
    #1 chk("eret_epc", cp0_epc, 32'h8000_0100);
    chk("eret_type", {28'd0, exception_type}, 32'd9);
    run_cycle();
    idle(); #1;
    chk("eret_exl", {31'd0, status_o[1]}, 32'd0);

    // EPC written in the same cycle as ERET is forwarded
    mem_valid = 1; mem_exc_flags = 8'h80; wr_en = 1; wr_addr = 5'd14; wr_data = 32'h0000_1234;
    #1 chk("fwd_epc", cp0_epc, 32'h0000_1234);
    run_cycle();
    idle(); #1;
    chk("fwd_epc_kept", cp0_epc, 32'h0000_1234);

    // Count/Compare timer
    do_reset();
    wr_en = 1; wr_addr = 5'd11; wr_data = 32'd10;
    run_cycle();
    idle(); rd_addr = 5'd9;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle();
      if (timer_int) seen = 1;
    end
    chk("ti_seen", {31'd0, seen}, {31'd0, TIMER});
    wr_en = 1; wr_addr = 5'd11; wr_data = 32'h0000_FFFF;
    run_cycle();
    idle(); #1;
    chk("ti_cleared", {31'd0, timer_int}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      run_cycle();
    end

    // Reset in the middle of activity
    randomize_inputs();
    mem_valid = 1; mem_exc_flags = 8'h10; mem_stall = 0;
    do_reset();
    idle(); rd_addr = 5'd9; #1;
    chk("mid_rst_status", status_o, 32'h0040_0000);
    chk("mid_rst_epc", cp0_epc, 32'd0);
    chk("mid_rst_count", rd_data, 32'd0);
    rd_addr = 5'd8; #1;
    chk("mid_rst_badv", rd_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
